// File: rtl/serial_add_scheduler_pkg.sv
// Shared definitions for the bit-serial add scheduler: FSM encodings,
// requester IDs and the grant one-hot helper.
package serial_add_scheduler_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/serial_add_scheduler_fa.sv
// Gate-level 1-bit full adder used as the shared bit-slice datapath.
module FullAdder1bit_Structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p, g, pc;

  xor x0 (p, a, b);
  xor x1 (sum, p, cin);
  and a0 (g, a, b);
  and a1 (pc, p, cin);
  or  o0 (cout, g, pc);

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one full-adder cell between two requesters;
// each granted request runs a WIDTH-bit LSB-first serial addition.
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             owner;
  logic             ptr;
  logic             win;
  logic             any_req;
  logic             fa_s, fa_co;
  logic             last_bit;

  FullAdder1bit_Structural u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // ptr names the requester that wins a tie; it flips to the loser on every grant
  always_comb begin
    any_req  = req0 | req1;
    win      = (req0 & req1) ? ptr : req1;
    busy     = (state != IDLE);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= REQ0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      owner   <= REQ0;
      ptr     <= REQ0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            a_sh  <= win ? a1 : a0;
            b_sh  <= win ? b1 : b0;
            carry <= win ? cin1 : cin0;
            cnt   <= '0;
            owner <= win;
            ptr   <= ~win;
            gnt   <= id_onehot(win);
            state <= RUN;
          end
        end
        RUN: begin
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          // The final sum bit is merged here rather than read from res a cycle later
          if (last_bit) begin
            sum     <= {fa_s, res[WIDTH-1:1]};
            cout    <= fa_co;
            done    <= 1'b1;
            done_id <= owner;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed and randomized checks of serial_add_scheduler against an
// arithmetic / round-robin reference model.
module tb_serial_add_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, cin0, cin1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;

  int           checks = 0;
  int           errors = 0;
  logic         nxt = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_id = 1'b0;

  serial_add_scheduler #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .cin0    (cin0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .cin1    (cin1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request/result transaction; the model picks the winner by the tie rule,
  // and the result is plain integer addition of the grant-time operands.
  task automatic op(input bit r0, input bit r1, input bit keep, input int exp_wait,
                    input int raise1_at, input bit scramble);
    int           waited = 0;
    bit           got = 1'b0;
    logic         w;
    logic [W-1:0] ea, eb;
    logic         ec;
    logic [W:0]   full;
    req0 = r0;
    req1 = r1;
    while (!got && waited < 12) begin
      @(negedge clk);
      waited++;
      if (gnt != 2'b00) got = 1'b1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (!got) begin
      req0 = 1'b0;
      req1 = 1'b0;
      return;
    end
    chk("gnt_wait", 32'(waited), 32'(exp_wait));
    w = (r0 && r1) ? nxt : r1;
    chk("gnt_onehot", 32'(gnt), w ? 32'd2 : 32'd1);
    chk("busy_at_gnt", 32'(busy), 32'd1);
    chk("result_held", 32'({cout, sum}), 32'({last_cout, last_sum}));
    chk("id_held", 32'(done_id), 32'(last_id));
    ea  = w ? a1 : a0;
    eb  = w ? b1 : b0;
    ec  = w ? cin1 : cin0;
    nxt = ~w;
    if (w) req1 = 1'b0; else req0 = 1'b0;
    if (!keep) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    if (scramble) begin
      a0 = W'($urandom); b0 = W'($urandom); cin0 = ~cin0;
      a1 = W'($urandom); b1 = W'($urandom); cin1 = ~cin1;
    end
    full = {1'b0, ea} + {1'b0, eb} + (W+1)'(ec);
    for (int c = 1; c <= W; c++) begin
      if (c == raise1_at) req1 = 1'b1;
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("gnt_quiet", 32'(gnt), 32'd0);
      chk("done_flag", 32'(done), 32'(c == W));
    end
    chk("sum", 32'(sum), 32'(full[W-1:0]));
    chk("cout", 32'(cout), 32'(full[W]));
    chk("done_id", 32'(done_id), 32'(w));
    last_sum  = full[W-1:0];
    last_cout = full[W];
    last_id   = w;
  endtask

  initial begin
    bit   saw_done;
    logic [2:0] pat;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_id", 32'(done_id), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    a0 = 4'd3; b0 = 4'd5; cin0 = 1'b0;
    op(1, 0, 0, 1, -1, 0);
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0;
    op(0, 1, 0, 2, -1, 0);
    a1 = 4'h7; b1 = 4'h8; cin1 = 1'b1;
    op(0, 1, 0, 2, -1, 0);

    a0 = 4'd2; b0 = 4'd2; cin0 = 1'b0;
    a1 = 4'd9; b1 = 4'd4; cin1 = 1'b1;
    for (int i = 0; i < 4; i++) op(1, 1, 1, 2, -1, 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    a0 = 4'd6; b0 = 4'd3; cin0 = 1'b1;
    op(1, 0, 0, 1, 2, 0);
    a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
    op(0, 1, 0, 2, -1, 0);

    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    op(1, 0, 0, 2, -1, 1);

    repeat (3) @(negedge clk);
    a0 = 4'd5; b0 = 4'd6; cin0 = 1'b1;
    req0 = 1'b1;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'd1);
    req0 = 1'b0;
    nxt  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_id", 32'(done_id), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nxt = 1'b0; last_sum = '0; last_cout = 1'b0; last_id = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    a0 = 4'd1; b0 = 4'd1; cin0 = 1'b0;
    a1 = 4'd4; b1 = 4'd4; cin1 = 1'b0;
    op(1, 1, 0, 1, -1, 0);

    for (int i = 0; i < 20; i++) begin
      pat = 3'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
      op(pat[0], pat[1], 0, 2, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
